// File: rtl/dm_arbiter.sv
// Two-port arbiter sharing a single-ported data memory between the CPU datapath
// (port 0) and a loader/debug master (port 1): one-cycle access, one-cycle ack.
module dm_arbiter #(
    parameter int ADDR_W     = 4,
    parameter int DATA_W     = 32,
    parameter bit FIXED_PRIO = 1'b0
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              req0,
    input  logic              we0,
    input  logic [ADDR_W-1:0] addr0,
    input  logic [DATA_W-1:0] wdata0,
    output logic              ack0,
    output logic [DATA_W-1:0] rdata0,
    input  logic              req1,
    input  logic              we1,
    input  logic [ADDR_W-1:0] addr1,
    input  logic [DATA_W-1:0] wdata1,
    output logic              ack1,
    output logic [DATA_W-1:0] rdata1,
    output logic [DATA_W-1:0] dm_write_data,
    output logic              dm_MemWrite,
    output logic              dm_MemRead,
    output logic [ADDR_W-1:0] dm_addr,
    input  logic [DATA_W-1:0] dm_read_data
);

    typedef enum logic {
        IDLE = 1'b0,
        ACK  = 1'b1
    } state_t;

    state_t            state_reg;
    logic              last_grant_reg;
    logic              ack0_reg;
    logic              ack1_reg;
    logic [DATA_W-1:0] rdata_reg;

    logic any_req;
    logic grant;
    logic access;

    // grant is only meaningful when any_req is set
    always_comb begin
        any_req = req0 | req1;
        if (req0 && req1) begin
            grant = FIXED_PRIO ? 1'b0 : ~last_grant_reg;
        end else begin
            grant = req1;
        end
        access = (state_reg == IDLE) && any_req && !rst;
    end

    // The memory pins are live only during an access cycle; reset blocks any write.
    always_comb begin
        dm_write_data = '0;
        dm_MemWrite   = 1'b0;
        dm_MemRead    = 1'b0;
        dm_addr       = '0;
        if (access) begin
            dm_addr       = grant ? addr1  : addr0;
            dm_write_data = grant ? wdata1 : wdata0;
            dm_MemWrite   = grant ? we1    : we0;
            dm_MemRead    = grant ? ~we1   : ~we0;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_reg      <= IDLE;
            last_grant_reg <= 1'b1;
            ack0_reg       <= 1'b0;
            ack1_reg       <= 1'b0;
            rdata_reg      <= '0;
        end else begin
            case (state_reg)
                IDLE: begin
                    ack0_reg <= 1'b0;
                    ack1_reg <= 1'b0;
                    if (any_req) begin
                        // for a write this captures the pre-write contents
                        rdata_reg      <= dm_read_data;
                        last_grant_reg <= grant;
                        ack0_reg       <= ~grant;
                        ack1_reg       <= grant;
                        state_reg      <= ACK;
                    end
                end
                ACK: begin
                    ack0_reg  <= 1'b0;
                    ack1_reg  <= 1'b0;
                    state_reg <= IDLE;
                end
                default: begin
                    ack0_reg  <= 1'b0;
                    ack1_reg  <= 1'b0;
                    state_reg <= IDLE;
                end
            endcase
        end
    end

    assign ack0   = ack0_reg;
    assign ack1   = ack1_reg;
    assign rdata0 = rdata_reg;
    assign rdata1 = rdata_reg;

endmodule

// File: tb/tb_dm_arbiter.sv
// Bench for dm_arbiter: directed scenarios plus randomized two-port traffic,
// checked by a per-port scoreboard fed from a reference memory model.
module tb_dm_arbiter;

    localparam int AW = 4;
    localparam int DW = 32;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    logic          req   [2];
    logic          we    [2];
    logic [AW-1:0] addr  [2];
    logic [DW-1:0] wdata [2];
    logic          ack0, ack1;
    logic [DW-1:0] rdata0, rdata1;
    logic [DW-1:0] dm_write_data, dm_read_data;
    logic          dm_MemWrite, dm_MemRead;
    logic [AW-1:0] dm_addr;

    logic [DW-1:0] mem [16];
    assign dm_read_data = mem[dm_addr];
    always @(posedge clk) if (dm_MemWrite) mem[dm_addr] <= dm_write_data;

    dm_arbiter #(.ADDR_W(AW), .DATA_W(DW), .FIXED_PRIO(1'b0)) dut (
        .clk(clk), .rst(rst),
        .req0(req[0]), .we0(we[0]), .addr0(addr[0]), .wdata0(wdata[0]),
        .ack0(ack0), .rdata0(rdata0),
        .req1(req[1]), .we1(we[1]), .addr1(addr[1]), .wdata1(wdata[1]),
        .ack1(ack1), .rdata1(rdata1),
        .dm_write_data(dm_write_data), .dm_MemWrite(dm_MemWrite),
        .dm_MemRead(dm_MemRead), .dm_addr(dm_addr), .dm_read_data(dm_read_data)
    );

    // Fixed-priority instance, exercised only for its grant behaviour.
    logic          fp_req0, fp_req1, fp_ack0, fp_ack1;
    logic [DW-1:0] fp_rdata0, fp_rdata1, fp_wd, fp_rd;
    logic          fp_mw, fp_mr;
    logic [AW-1:0] fp_addr;
    assign fp_rd = {28'h0, fp_addr} ^ 32'hA5A5_0000;

    dm_arbiter #(.ADDR_W(AW), .DATA_W(DW), .FIXED_PRIO(1'b1)) dut_fp (
        .clk(clk), .rst(rst),
        .req0(fp_req0), .we0(1'b0), .addr0(4'd3), .wdata0(32'h0),
        .ack0(fp_ack0), .rdata0(fp_rdata0),
        .req1(fp_req1), .we1(1'b0), .addr1(4'd4), .wdata1(32'h0),
        .ack1(fp_ack1), .rdata1(fp_rdata1),
        .dm_write_data(fp_wd), .dm_MemWrite(fp_mw),
        .dm_MemRead(fp_mr), .dm_addr(fp_addr), .dm_read_data(fp_rd)
    );

    int checks = 0;
    int errors = 0;

    logic [DW-1:0] ref_mem [16];
    logic [DW-1:0] exp_q0 [$];
    logic [DW-1:0] exp_q1 [$];
    int            ack_order [$];
    bit            record_order = 1'b0;
    int            exp_writes = 0;
    int            seen_writes = 0;
    logic          prev_ack0 = 1'b0;
    logic          prev_ack1 = 1'b0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Issue one transaction on port p; expected read data comes from the reference memory.
    task automatic txn(input int p, input bit w, input logic [AW-1:0] a,
                       input logic [DW-1:0] d, input int exp_wait);
        int waited = 0;
        bit got = 1'b0;
        if (p == 0) exp_q0.push_back(ref_mem[a]);
        else        exp_q1.push_back(ref_mem[a]);
        if (w) begin
            ref_mem[a] = d;
            exp_writes++;
        end
        req[p] = 1'b1; we[p] = w; addr[p] = a; wdata[p] = d;
        while (!got && waited < 10) begin
            @(negedge clk);
            waited++;
            got = (p == 0) ? ack0 : ack1;
        end
        if (!got)
            check($sformatf("port%0d ack timeout", p), 64'(got), 64'd1);
        else if (exp_wait > 0)
            check($sformatf("port%0d latency", p), 64'(waited), 64'(exp_wait));
        else
            check($sformatf("port%0d latency<=4", p), 64'(waited <= 4), 64'd1);
        @(posedge clk);
        #1;
        req[p] = 1'b0;
    endtask

    // Monitor: pops the scoreboard whenever an ack is presented.
    always @(negedge clk) begin
        if (dm_MemWrite) seen_writes <= seen_writes + 1;
        if (rst) check("dm quiet in reset", {62'h0, dm_MemWrite, dm_MemRead}, 64'h0);
        if (ack0 || ack1) begin
            check("acks exclusive", 64'(ack0 & ack1), 64'h0);
            check("dm idle during ack", {62'h0, dm_MemWrite, dm_MemRead}, 64'h0);
        end
        if (ack0) begin
            check("ack0 single pulse", 64'(prev_ack0), 64'h0);
            if (exp_q0.size() == 0) check("port0 unexpected ack", 64'h1, 64'h0);
            else                    check("rdata0", 64'(rdata0), 64'(exp_q0.pop_front()));
            if (record_order) ack_order.push_back(0);
        end
        if (ack1) begin
            check("ack1 single pulse", 64'(prev_ack1), 64'h0);
            if (exp_q1.size() == 0) check("port1 unexpected ack", 64'h1, 64'h0);
            else                    check("rdata1", 64'(rdata1), 64'(exp_q1.pop_front()));
            if (record_order) ack_order.push_back(1);
        end
        prev_ack0 <= ack0;
        prev_ack1 <= ack1;
    end

    initial begin
        #200000;
        $display("FAIL global timeout: simulation did not complete");
        $fatal(1, "timeout");
    end

    initial begin
        int wbefore;
        int waited;
        bit got;
        int a0, a1;
        for (int i = 0; i < 16; i++) begin
            mem[i] = '0;
            ref_mem[i] = '0;
        end
        for (int p = 0; p < 2; p++) begin
            req[p] = 1'b0; we[p] = 1'b0; addr[p] = '0; wdata[p] = '0;
        end
        fp_req0 = 1'b0;
        fp_req1 = 1'b0;

        // Reset held with a pending write on port 0
        req[0] = 1'b1; we[0] = 1'b1; addr[0] = 4'd5; wdata[0] = 32'h1111_1111;
        repeat (2) begin
            @(negedge clk);
            check("reset ack0", 64'(ack0), 64'h0);
            check("reset dm_MemWrite", 64'(dm_MemWrite), 64'h0);
            check("reset rdata0", 64'(rdata0), 64'h0);
        end
        @(posedge clk);
        #1;
        rst = 1'b0;
        check("no write during reset", 64'(seen_writes), 64'h0);
        txn(0, 1'b1, 4'd5, 32'h1111_1111, 2);
        check("post-reset write once", 64'(seen_writes), 64'h1);
        check("dm[5] after reset write", 64'(mem[5]), 64'h1111_1111);

        // Port 0 write then read
        wbefore = seen_writes;
        txn(0, 1'b1, 4'd3, 32'hDEAD_BEEF, 2);
        check("single MemWrite cycle", 64'(seen_writes - wbefore), 64'h1);
        txn(0, 1'b0, 4'd3, 32'h0, 2);

        // Write returns pre-write contents
        txn(1, 1'b1, 4'd7, 32'h0000_0042, 2);
        txn(1, 1'b1, 4'd7, 32'hCAFE_F00D, 2);
        txn(1, 1'b0, 4'd7, 32'h0, 2);

        // Round-robin contention right after reset
        txn(0, 1'b1, 4'd1, 32'h1111_0001, 2);
        txn(1, 1'b1, 4'd2, 32'h2222_0002, 2);
        rst = 1'b1;
        #10;
        rst = 1'b0;
        record_order = 1'b1;
        fork
            begin txn(0, 1'b0, 4'd1, 32'h0, 0); txn(0, 1'b0, 4'd1, 32'h0, 0); end
            begin txn(1, 1'b0, 4'd2, 32'h0, 0); txn(1, 1'b0, 4'd2, 32'h0, 0); end
        join
        record_order = 1'b0;
        check("rr ack count", 64'(ack_order.size()), 64'd4);
        for (int i = 0; i < 4; i++)
            if (i < ack_order.size())
                check($sformatf("rr grant %0d", i), 64'(ack_order[i]), 64'(i % 2));

        // Reset asserted in the ack cycle of a port 1 write
        exp_q1.push_back(ref_mem[9]);
        ref_mem[9] = 32'h9999_ABCD;
        exp_writes++;
        req[1] = 1'b1; we[1] = 1'b1; addr[1] = 4'd9; wdata[1] = 32'h9999_ABCD;
        waited = 0;
        got = 1'b0;
        while (!got && waited < 10) begin
            @(negedge clk);
            waited++;
            got = ack1;
        end
        check("rst-in-ack: ack1 seen", 64'(got), 64'h1);
        rst = 1'b1;
        req[1] = 1'b0;
        @(negedge clk);
        check("ack1 cleared by reset", 64'(ack1), 64'h0);
        check("ack0 low after reset", 64'(ack0), 64'h0);
        @(posedge clk);
        #1;
        rst = 1'b0;
        check("dm[9] retained", 64'(mem[9]), 64'h9999_ABCD);
        txn(0, 1'b0, 4'd9, 32'h0, 2);

        // Fixed priority: port 1 starves while port 0 keeps requesting
        fp_req0 = 1'b1;
        fp_req1 = 1'b1;
        a0 = 0;
        a1 = 0;
        repeat (10) begin
            @(negedge clk);
            a0 += int'(fp_ack0);
            a1 += int'(fp_ack1);
        end
        check("fp ack1 starved", 64'(a1), 64'h0);
        check("fp ack0 count", 64'(a0), 64'd5);
        @(posedge clk);
        #1;
        fp_req0 = 1'b0;
        waited = 0;
        got = 1'b0;
        while (!got && waited < 6) begin
            @(negedge clk);
            waited++;
            got = fp_ack1;
        end
        check("fp ack1 follows", 64'(got && waited <= 2), 64'h1);
        @(posedge clk);
        #1;
        fp_req1 = 1'b0;

        // Randomized traffic on disjoint address halves per port
        fork
            for (int n = 0; n < 30; n++) begin
                txn(0, 1'($urandom_range(0, 1)), 4'($urandom_range(0, 7)), $urandom, 0);
                repeat ($urandom_range(0, 2)) #10;
            end
            for (int n = 0; n < 30; n++) begin
                txn(1, 1'($urandom_range(0, 1)), 4'(8 + $urandom_range(0, 7)), $urandom, 0);
                repeat ($urandom_range(0, 2)) #10;
            end
        join
        #20;
        check("port0 queue drained", 64'(exp_q0.size()), 64'h0);
        check("port1 queue drained", 64'(exp_q1.size()), 64'h0);
        check("write count", 64'(seen_writes), 64'(exp_writes));
        for (int i = 0; i < 16; i++)
            check($sformatf("final dm[%0d]", i), 64'(mem[i]), 64'(ref_mem[i]));

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
